// File: rtl/oc_iic_master.sv
// Byte-level IIC master: sequences SCL/SDA open-drain tristate controls from a
// START/STOP/WRITE/READ command stream, with clock stretching and arbitration.
module oc_iic_master #(
    parameter int ClockHz    = 100_000_000,
    parameter int IicHz      = 100_000,
    parameter int SyncCycles = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [1:0] cmdOp,
    input  logic [7:0] cmdData,
    input  logic       cmdNack,
    output logic       rspValid,
    output logic [7:0] rspData,
    output logic       rspNack,
    output logic       rspArbLost,
    output logic       busy,
    output logic       busOwned,
    input  logic       iicScl,
    output logic       iicSclTristate,
    input  logic       iicSda,
    output logic       iicSdaTristate
);
    localparam int QuarterCycles = ClockHz / (4 * IicHz);
    localparam int CntW = (QuarterCycles > 2) ? $clog2(QuarterCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(QuarterCycles - 1);

    localparam logic [1:0] OpStart = 2'd0;
    localparam logic [1:0] OpStop  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;
    localparam logic [1:0] OpRead  = 2'd3;

    if (QuarterCycles < 2) begin : gQuarterCheck
        $error("QuarterCycles must be >= 2");
    end
    if (SyncCycles < 2) begin : gSyncCheck
        $error("SyncCycles must be >= 2");
    end

    typedef enum logic [1:0] {Idle = 2'd0, Run = 2'd1, Resp = 2'd2} state_t;

    state_t state, nextState;
    logic [SyncCycles-1:0] sclSync, sdaSync;
    logic [CntW-1:0] cnt, nCnt;
    logic [1:0] quarter, nQuarter, opR, nOp;
    logic [3:0] bitIdx, nBitIdx;
    logic [7:0] txData, nTxData, rxData, nRx;
    logic rdNack, nRdNack, ackR, nAck, arbR, nArb;
    logic sclT, nSclT, sdaT, nSdaT, busOwnedR, nBusOwned;
    logic cmdReadyR, busyR, rspValidR, rspNackR, rspArbR;
    logic [7:0] rspDataR;
    logic sclS, sdaS, accept, stallS, qEndS, lastQ, sampleS, arbS;
    logic [1:0] qNext;

    // Bit value this master puts on SDA for a given bit slot (1 = released).
    function automatic logic txBitF(input logic [1:0] op, input logic [7:0] data,
                                   input logic nack, input logic [3:0] idx);
        logic b;
        b = 1'b1;
        case (op)
            OpWrite: if (idx < 4'd8) b = data[3'd7 - idx[2:0]]; else b = 1'b1;
            OpRead:  if (idx == 4'd8) b = nack; else b = 1'b1;
            default: b = 1'b1;
        endcase
        return b;
    endfunction

    assign sclS    = sclSync[SyncCycles-1];
    assign sdaS    = sdaSync[SyncCycles-1];
    assign accept  = (state == Idle) && cmdReadyR && cmdValid;
    assign stallS  = (state == Run) && (quarter == 2'd1) && !sclS;
    assign qEndS   = !stallS && (cnt == CntLast);
    assign lastQ   = (quarter == 2'd3) && (!opR[1] || (bitIdx == 4'd8));
    assign sampleS = (state == Run) && (quarter == 2'd2) && (cnt == '0);
    assign qNext   = quarter + 2'd1;
    // Lost arbitration: SDA found low where we released it intending a 1.
    assign arbS = (state == Run) && !sdaS &&
                  ((sampleS && ((opR == OpStart) ||
                                ((opR == OpWrite) && (bitIdx < 4'd8) &&
                                 txBitF(opR, txData, rdNack, bitIdx)))) ||
                   ((opR == OpStop) && (quarter == 2'd3) && (cnt == '0)));

    // Pad input synchronizers (bus idles high).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sclSync <= {SyncCycles{1'b1}};
            sdaSync <= {SyncCycles{1'b1}};
        end else begin
            sclSync <= {sclSync[SyncCycles-2:0], iicScl};
            sdaSync <= {sdaSync[SyncCycles-2:0], iicSda};
        end
    end

    // State register together with the datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= Idle;       cnt <= '0;          quarter <= 2'd0;
            bitIdx <= 4'd0;      opR <= 2'd0;        txData <= 8'd0;
            rxData <= 8'd0;      rdNack <= 1'b0;     ackR <= 1'b0;
            arbR <= 1'b0;        sclT <= 1'b1;       sdaT <= 1'b1;
            busOwnedR <= 1'b0;   cmdReadyR <= 1'b0;  busyR <= 1'b0;
            rspValidR <= 1'b0;   rspDataR <= 8'd0;   rspNackR <= 1'b0;
            rspArbR <= 1'b0;
        end else begin
            state <= nextState;  cnt <= nCnt;        quarter <= nQuarter;
            bitIdx <= nBitIdx;   opR <= nOp;         txData <= nTxData;
            rxData <= nRx;       rdNack <= nRdNack;  ackR <= nAck;
            arbR <= nArb;        sclT <= nSclT;      sdaT <= nSdaT;
            busOwnedR <= nBusOwned;
            cmdReadyR <= (nextState == Idle);
            busyR     <= (nextState != Idle);
            rspValidR <= (nextState == Resp);
            if ((state == Run) && (nextState == Resp)) begin
                rspDataR <= (opR == OpRead) ? nRx : 8'd0;
                rspNackR <= (opR == OpWrite) ? nAck : 1'b0;
                rspArbR  <= nArb;
            end else begin
                rspDataR <= rspDataR;
                rspNackR <= rspNackR;
                rspArbR  <= rspArbR;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            Idle:    if (accept) nextState = Run; else nextState = Idle;
            Run:     if (arbS || (qEndS && lastQ)) nextState = Resp; else nextState = Run;
            Resp:    nextState = Idle;
            default: nextState = Idle;
        endcase
    end

    // Quarter sequencing, line control and sampling.
    always_comb begin
        nCnt = cnt;          nQuarter = quarter;  nBitIdx = bitIdx;
        nOp = opR;           nTxData = txData;    nRdNack = rdNack;
        nRx = rxData;        nAck = ackR;         nArb = arbR;
        nSclT = sclT;        nSdaT = sdaT;        nBusOwned = busOwnedR;
        case (state)
            Idle: begin
                if (accept) begin
                    nOp = cmdOp;  nTxData = cmdData;  nRdNack = cmdNack;
                    nCnt = '0;    nQuarter = 2'd0;    nBitIdx = 4'd0;
                    nRx = 8'd0;   nAck = 1'b0;        nArb = 1'b0;
                    case (cmdOp)
                        OpStart: nSdaT = 1'b1;
                        OpStop:  begin nSdaT = 1'b0; nSclT = 1'b0; end
                        default: nSdaT = txBitF(cmdOp, cmdData, cmdNack, 4'd0);
                    endcase
                end else begin
                    nCnt = cnt;
                end
            end
            Run: begin
                if (arbS) begin
                    nSclT = 1'b1;  nSdaT = 1'b1;  nArb = 1'b1;  nBusOwned = 1'b0;
                end else begin
                    if (sampleS && (opR == OpWrite) && (bitIdx == 4'd8)) nAck = sdaS;
                    else if (sampleS && (opR == OpRead) && (bitIdx < 4'd8)) nRx = {rxData[6:0], sdaS};
                    else nAck = ackR;
                    if (stallS) begin
                        nCnt = cnt;
                    end else if (cnt != CntLast) begin
                        nCnt = cnt + CntW'(1);
                    end else begin
                        nCnt = '0;
                        if (lastQ) begin
                            if (opR == OpStart) nBusOwned = 1'b1;
                            else if (opR == OpStop) nBusOwned = 1'b0;
                            else nBusOwned = busOwnedR;
                        end else if (quarter == 2'd3) begin
                            nQuarter = 2'd0;
                            nBitIdx  = bitIdx + 4'd1;
                            nSdaT    = txBitF(opR, txData, rdNack, bitIdx + 4'd1);
                        end else begin
                            nQuarter = qNext;
                            case (qNext)
                                2'd1: nSclT = 1'b1;
                                2'd2: if (opR == OpStart) nSdaT = 1'b0;
                                      else if (opR == OpStop) nSdaT = 1'b1;
                                      else nSdaT = sdaT;
                                2'd3: if (opR != OpStop) nSclT = 1'b0; else nSclT = sclT;
                                default: nSclT = sclT;
                            endcase
                        end
                    end
                end
            end
            default: nCnt = cnt;
        endcase
    end

    assign cmdReady       = cmdReadyR;
    assign busy           = busyR;
    assign busOwned       = busOwnedR;
    assign rspValid       = rspValidR;
    assign rspData        = rspDataR;
    assign rspNack        = rspNackR;
    assign rspArbLost     = rspArbR;
    assign iicSclTristate = sclT;
    assign iicSdaTristate = sdaT;
endmodule

// File: doc/oc_iic_master.md
Name: oc_iic_master

Overview:
- Byte-level IIC master engine that sequences the SCL/SDA open-drain tristate controls of an IIC port from a simple command stream.
- Sits between a CSR/command source (firmware FIFO or offload logic) and the IIC pad tristates; replaces manual bit-banging of the SCL/SDA control bits.
- Supports START/repeated START, STOP, byte write with ACK sampling, byte read with ACK/NACK generation, clock stretching and arbitration-loss detection.

Parameters:
- ClockHz, 100_000_000, frequency of clock in Hz.
- IicHz, 100_000, target SCL frequency in Hz.
- SyncCycles, 2, synchronizer depth for iicScl/iicSda inputs (>=2).
- QuarterCycles, ClockHz/(4*IicHz), clocks per quarter bit period (derived localparam, must be >=2; static error otherwise).

Ports:
- clock  in  1  block clock.
- reset  in  1  asynchronous, active-low reset.
- cmdValid  in  1  command valid.
- cmdReady  out  1  command accepted when cmdValid&&cmdReady.
- cmdOp  in  2  0=START, 1=STOP, 2=WRITE, 3=READ.
- cmdData  in  8  WRITE byte, MSB first.
- cmdNack  in  1  READ only: 1 drives NACK, 0 drives ACK.
- rspValid  out  1  one-cycle completion pulse, no backpressure.
- rspData  out  8  READ byte (0 for other ops).
- rspNack  out  1  WRITE: sampled ACK bit (1=NACK); else 0.
- rspArbLost  out  1  arbitration lost during this command.
- busy  out  1  command in progress.
- busOwned  out  1  START issued, STOP not yet completed.
- iicScl  in  1  SCL pad input (async).
- iicSclTristate  out  1  1=release SCL, 0=drive low.
- iicSda  in  1  SDA pad input (async).
- iicSdaTristate  out  1  1=release SDA, 0=drive low.

Behaviour:
- Reset (asserted): iicSclTristate=1, iicSdaTristate=1, cmdReady=0, rspValid=0, rspData=0, rspNack=0, rspArbLost=0, busy=0, busOwned=0, state IDLE. Reset mid-operation releases both lines immediately (async). First cycle after deassertion cmdReady=1.
- iicScl/iicSda pass through SyncCycles flops; all sampling uses synced values.
- cmdReady = (state==IDLE). Accepted command -> busy=1 next cycle; cmd fields captured at accept.
- Each command runs as 4 quarters q0..q3 (START/STOP) or 9 bits x 4 quarters (WRITE/READ: 8 data + ACK). Quarter counter counts QuarterCycles clocks.
- START: q0 release SDA (SCL unchanged); q1 release SCL, stretch-wait; q2 drive SDA low; q3 drive SCL low. Sets busOwned. Same sequence serves repeated START.
- STOP: q0 drive SDA low (SCL low); q1 release SCL, stretch-wait; q2 release SDA; q3 hold. Clears busOwned. Lines end released.
- Bit: q0 set SDA (data bit, or released for receive/ACK-read); q1 release SCL, stretch-wait; at first cycle of q2 sample synced SDA; q3 drive SCL low. After WRITE/READ SCL stays driven low.
- WRITE: bits 7..0 from cmdData, ACK bit SDA released, sample -> rspNack.
- READ: bits SDA released, samples shift into rspData MSB first; ACK bit drives SDA = cmdNack (tristate=cmdNack).
- Stretch-wait: q1 counter does not start until synced SCL==1; no timeout.
- Arbitration: at q2 sample of any bit where this master released SDA for a data bit it intended as 1 (WRITE data, START q1/q2 check SDA==1 at q1 end, STOP q2 end), sampled 0 -> release both lines same cycle, rspArbLost=1, busOwned=0, go to RESP. ACK/receive bits never flag arbitration.
- RESP: rspValid=1 for exactly one cycle with outputs stable that cycle; next cycle IDLE, busy=0. Latency accept-to-rspValid: START/STOP = 4*QuarterCycles+stretch+~2; byte = 36*QuarterCycles+stretch+~2.
- Commands are not illegal in any bus state: WRITE/READ without START are executed as-is (caller's responsibility).
- cmdValid while busy is held, not dropped.

Test Plan:
- QuarterCycles=4; START, WRITE 0xA5, slave model ACKs -> SDA bits 1,0,1,0,0,1,0,1 on SCL rising edges, rspValid with rspNack=0, rspArbLost=0, busOwned=1.
- WRITE 0x3C with no slave (SDA pulled high) -> rspNack=1; then STOP -> SDA rises while SCL high, busOwned=0, both tristates=1.
- READ cmdNack=1, slave drives 0x5E -> rspData=0x5E, SDA released during ACK bit; READ cmdNack=0 -> SDA driven low in ACK bit.
- Slave holds SCL low 20 cycles in bit 3 of a WRITE -> bit period extends by 20 cycles, data unchanged, rspNack correct.
- Other master pulls SDA low during bit 1 of WRITE 0xFF -> rspArbLost=1, both tristates=1 same cycle as q2 sample, busOwned=0.
- Assert reset mid-READ bit 4 -> tristates=1 and rspValid=0 immediately; after release cmdReady=1, new START completes normally.
